// File: rtl/change_dispenser.sv
// Pays out a change amount as timed ejector pulses, large coins first, then unit coins.
// Outputs are registered copies of the internal state, so they trail it by one cycle.
module change_dispenser #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned FIVE_VAL  = 5,
  parameter int unsigned PULSE_LEN = 2_500_000,
  parameter int unsigned GAP_LEN   = 2_500_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] amount,
  input  logic             abort,
  output logic             eject_five,
  output logic             eject_one,
  output logic [WIDTH-1:0] remaining,
  output logic             busy,
  output logic             done
);

  localparam int unsigned MAX_LEN = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int unsigned CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_LEN - 1);
  localparam logic [WIDTH-1:0] FIVE       = WIDTH'(FIVE_VAL);
  localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_PULSE,
    S_GAP,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             coin_five_q, coin_five_d;
  logic             abort_q, abort_d;
  logic             eject_five_q, eject_five_d;
  logic             eject_one_q, eject_one_d;
  logic [WIDTH-1:0] remaining_q, remaining_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] rem_paid;

  // Amount left after the coin currently in PULSE; saturates at zero.
  always_comb begin
    rem_paid = '0;
    if (coin_five_q) begin
      if (rem_q >= FIVE) rem_paid = rem_q - FIVE;
    end else begin
      if (rem_q != '0) rem_paid = rem_q - ONE;
    end
  end

  // Next-state and datapath.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    coin_five_d = coin_five_q;
    abort_d     = abort_q | (abort & (state_q != S_IDLE));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_d   = amount;
          abort_d = 1'b0;
          state_d = S_SELECT;
        end
      end
      S_SELECT: begin
        cnt_d = '0;
        if (abort_q || (rem_q == '0)) begin
          state_d = S_DONE;
        end else begin
          coin_five_d = (rem_q >= FIVE);
          state_d     = S_PULSE;
        end
      end
      S_PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          rem_d   = rem_paid;
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_SELECT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered outputs decoded from the current state.
  always_comb begin
    eject_five_d = (state_q == S_PULSE) & coin_five_q;
    eject_one_d  = (state_q == S_PULSE) & ~coin_five_q;
    remaining_d  = rem_q;
    busy_d       = (state_q != S_IDLE);
    done_d       = (state_q == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      rem_q        <= '0;
      cnt_q        <= '0;
      coin_five_q  <= 1'b0;
      abort_q      <= 1'b0;
      eject_five_q <= 1'b0;
      eject_one_q  <= 1'b0;
      remaining_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      cnt_q        <= cnt_d;
      coin_five_q  <= coin_five_d;
      abort_q      <= abort_d;
      eject_five_q <= eject_five_d;
      eject_one_q  <= eject_one_d;
      remaining_q  <= remaining_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign eject_five = eject_five_q;
  assign eject_one  = eject_one_q;
  assign remaining  = remaining_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
